// File: rtl/data_memory_responder.sv
// Memory-stage load/store responder: accepts one request at a time and
// performs a byte/half/word access on an internal little-endian RAM after a
// fixed latency. It returns extended load data with a one-cycle response
// pulse and requests a pipeline freeze while the access is in flight.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValidM,
    output logic        ReqReadyM,
    input  logic        MemWriteM,
    input  logic [2:0]  AddressingControlM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        RespValidM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        StallM
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [2:0]            r_ctrl;
    logic                  r_we;
    logic                  r_mis;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [WORDS];

    logic                  w_accept;
    logic                  w_done;
    logic                  w_mis_in;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic [1:0]            w_lane;
    logic [31:0]           w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [3:0]            w_be;
    logic [31:0]           w_wlane;
    logic                  w_unused_addr;

    assign w_unused_addr = ^ALUResultM[31:ADDR_WIDTH];

    assign w_accept = (r_state == IDLE) && ReqValidM;
    assign w_done   = (r_state == ACCESS) && (r_cnt == '0);
    assign w_idx    = r_addr[ADDR_WIDTH-1:2];
    assign w_lane   = r_addr[1:0];
    assign w_word   = r_mem[w_idx];
    assign w_byte   = w_word[8*w_lane +: 8];
    assign w_half   = w_lane[1] ? w_word[31:16] : w_word[15:0];

    // Classify the incoming request as misaligned or illegal at accept time
    always_comb begin
        w_mis_in = 1'b1;
        case (AddressingControlM)
            3'b000, 3'b100: w_mis_in = 1'b0;
            3'b001, 3'b101: w_mis_in = ALUResultM[0];
            3'b010:         w_mis_in = |ALUResultM[1:0];
            default:        w_mis_in = 1'b1;
        endcase
    end

    // State register; reset wins over every transition
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs decoded from the current state
    always_comb begin
        w_next     = r_state;
        ReqReadyM  = 1'b0;
        RespValidM = 1'b0;
        MisalignM  = 1'b0;
        StallM     = 1'b0;
        case (r_state)
            IDLE: begin
                ReqReadyM = 1'b1;
                StallM    = ReqValidM;
                if (ReqValidM) w_next = ACCESS;
            end
            ACCESS: begin
                StallM = 1'b1;
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                RespValidM = 1'b1;
                MisalignM  = r_mis;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the request on acceptance and count down the access latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_addr  <= ALUResultM[ADDR_WIDTH-1:0];
            r_wdata <= WriteDataM;
            r_ctrl  <= AddressingControlM;
            r_we    <= MemWriteM;
            r_mis   <= w_mis_in;
        end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Extract and extend the addressed byte/half/word for loads
    always_comb begin
        w_load = '0;
        case (r_ctrl)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            3'b010:  w_load = w_word;
            default: w_load = '0;
        endcase
    end

    // Lane enables and replicated store data by access size
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_ctrl[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // Response data register; stores and faulting accesses return zero
    always_ff @(posedge clk) begin
        if (rst)         r_rdata <= '0;
        else if (w_done) r_rdata <= (r_we || r_mis) ? '0 : w_load;
    end

    assign ReadDataM = r_rdata;

    // RAM byte-lane write on the final access cycle; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && w_done && r_we && !r_mis) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
            end
        end
    end

endmodule
